// File: rtl/seg7_disp_ctrl.sv
// Register front end for the 7-segment scan driver: shadow registers, scan/flash timing,
// and frame-aligned commit. Optional forced test pattern under SEG7_TEST_PATTERN_EN.
module seg7_disp_ctrl #(
  parameter int SCAN_DIV_W  = 17,
  parameter int FLASH_DIV_W = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [31:0] wr_data,
  output logic        wr_ack,
  output logic [2:0]  scan,
  output logic        flash_clk,
  output logic [31:0] hexs,
  output logic [7:0]  point,
  output logic [7:0]  les,
  output logic        frame_pending
);

  logic [SCAN_DIV_W-1:0]  scan_cnt;
  logic [FLASH_DIV_W-1:0] flash_cnt;
  logic [2:0]             ctrl;
  logic [31:0]            sh_hex, sh_hex_nxt, hex_q;
  logic [7:0]             sh_pt, sh_pt_nxt, pt_q;
  logic [7:0]             sh_les, sh_les_nxt, les_q;
  logic                   scan_tick, frame_end, commit, data_wr;

  assign scan_tick = ctrl[0] && (&scan_cnt);
  assign frame_end = scan_tick && (scan == 3'd7);
  assign commit    = frame_end || (ctrl[1] && frame_pending);
  assign data_wr   = wr_en && (wr_sel != 2'd3);

  // Next shadow values, so a commit on the write cycle picks up the new data
  always_comb begin
    sh_hex_nxt = sh_hex;
    sh_pt_nxt  = sh_pt;
    sh_les_nxt = sh_les;
    if (wr_en) begin
      case (wr_sel)
        2'd0:    sh_hex_nxt = wr_data;
        2'd1:    sh_pt_nxt  = wr_data[7:0];
        2'd2:    sh_les_nxt = wr_data[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt      <= '0;
      flash_cnt     <= '0;
      scan          <= 3'd0;
      flash_clk     <= 1'b0;
      ctrl          <= 3'b001;
      sh_hex        <= '0;
      sh_pt         <= '0;
      sh_les        <= '0;
      hex_q         <= '0;
      pt_q          <= '0;
      les_q         <= '0;
      wr_ack        <= 1'b0;
      frame_pending <= 1'b0;
    end else begin
      wr_ack    <= wr_en;
      flash_cnt <= flash_cnt + 1'b1;
      if (&flash_cnt) flash_clk <= ~flash_clk;
      if (ctrl[0]) scan_cnt <= scan_cnt + 1'b1;
      if (scan_tick) scan <= scan + 3'd1;
      sh_hex <= sh_hex_nxt;
      sh_pt  <= sh_pt_nxt;
      sh_les <= sh_les_nxt;
      if (wr_en && wr_sel == 2'd3) ctrl <= wr_data[2:0];
      if (commit) begin
        hex_q         <= sh_hex_nxt;
        pt_q          <= sh_pt_nxt;
        les_q         <= sh_les_nxt;
        frame_pending <= 1'b0;
      end else if (data_wr) begin
        frame_pending <= 1'b1;
      end
    end
  end

`ifdef SEG7_TEST_PATTERN_EN
  assign hexs  = ctrl[2] ? 32'h8888_8888 : hex_q;
  assign point = ctrl[2] ? 8'hFF : pt_q;
  assign les   = ctrl[2] ? 8'h00 : les_q;
`else
  logic unused_tp;
  assign unused_tp = ctrl[2];
  assign hexs  = hex_q;
  assign point = pt_q;
  assign les   = les_q;
`endif

endmodule

// File: tb/tb_seg7_disp_ctrl.sv
// Scoreboard bench for seg7_disp_ctrl: driver runs a frame-level reference model and queues
// the expected post-edge state; a monitor pops and compares after every edge.
module tb_seg7_disp_ctrl;
  localparam int SW = 2;
  localparam int FW = 4;
  localparam int SPF = (1 << SW) * 8;  // enabled cycles per scan frame

  typedef struct packed {
    logic        wr_ack;
    logic [2:0]  scan;
    logic        flash_clk;
    logic [31:0] hexs;
    logic [7:0]  point;
    logic [7:0]  les;
    logic        frame_pending;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_sel = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic        wr_ack, flash_clk, frame_pending;
  logic [2:0]  scan;
  logic [31:0] hexs;
  logic [7:0]  point, les;

  seg7_disp_ctrl #(.SCAN_DIV_W(SW), .FLASH_DIV_W(FW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .wr_ack(wr_ack), .scan(scan), .flash_clk(flash_clk), .hexs(hexs),
    .point(point), .les(les), .frame_pending(frame_pending)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: counts of enabled cycles and total cycles since reset
  int          m_active, m_cyc;
  logic [2:0]  m_ctrl;
  logic [31:0] m_sh_hex, m_hex;
  logic [7:0]  m_sh_pt, m_pt, m_sh_les, m_les;
  logic        m_pend, m_ack;

  function automatic exp_t model_out();
    exp_t e;
    e.wr_ack        = m_ack;
    e.scan          = 3'((m_active / (1 << SW)) % 8);
    e.flash_clk     = 1'((m_cyc / (1 << FW)) % 2);
    e.hexs          = m_hex;
    e.point         = m_pt;
    e.les           = m_les;
    e.frame_pending = m_pend;
`ifdef SEG7_TEST_PATTERN_EN
    if (m_ctrl[2]) begin
      e.hexs  = 32'h8888_8888;
      e.point = 8'hFF;
      e.les   = 8'h00;
    end
`endif
    return e;
  endfunction

  function automatic bit at_boundary();
    return m_ctrl[0] && (m_active % SPF == SPF - 1);
  endfunction

  task automatic model_step(input bit r, input bit we, input logic [1:0] s, input logic [31:0] d);
    bit commit;
    if (r) begin
      m_active = 0; m_cyc = 0; m_ctrl = 3'b001;
      m_sh_hex = 0; m_hex = 0; m_sh_pt = 0; m_pt = 0; m_sh_les = 0; m_les = 0;
      m_pend = 0; m_ack = 0;
      return;
    end
    commit = at_boundary() || (m_ctrl[1] && m_pend);
    if (we) begin
      if (s == 2'd0) m_sh_hex = d;
      if (s == 2'd1) m_sh_pt  = d[7:0];
      if (s == 2'd2) m_sh_les = d[7:0];
    end
    if (commit) begin
      m_hex = m_sh_hex; m_pt = m_sh_pt; m_les = m_sh_les; m_pend = 0;
    end else if (we && s != 2'd3) m_pend = 1;
    if (m_ctrl[0]) m_active++;
    if (we && s == 2'd3) m_ctrl = d[2:0];
    m_cyc++;
    m_ack = we;
  endtask

  task automatic cyc(input bit r, input bit we, input logic [1:0] s, input logic [31:0] d);
    @(negedge clk);
    rst = r; wr_en = we; wr_sel = s; wr_data = d;
    model_step(r, we, s, d);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 2'd0, 32'd0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, req);
    end
  endtask

  // Monitor: compare every edge's outputs against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_ack", 32'(wr_ack), 32'(e.wr_ack));
        chk("scan", 32'(scan), 32'(e.scan));
        chk("flash_clk", 32'(flash_clk), 32'(e.flash_clk));
        chk("hexs", hexs, e.hexs);
        chk("point", 32'(point), 32'(e.point));
        chk("les", 32'(les), 32'(e.les));
        chk("frame_pending", 32'(frame_pending), 32'(e.frame_pending));
      end
    end
  end

  initial begin
    int n;
    cyc(1, 0, 2'd0, 32'd0);
    cyc(1, 0, 2'd0, 32'd0);
    // mid-frame hex write waits for the 7->0 wrap
    idle(5);
    cyc(0, 1, 2'd0, 32'h1234_ABCD);
    idle(40);
    // immediate mode
    cyc(0, 1, 2'd3, 32'h0000_0003);
    cyc(0, 1, 2'd1, 32'hFFFF_FFA5);
    idle(3);
    cyc(0, 1, 2'd3, 32'hFFFF_FFF9);
    // write landing exactly on the frame boundary
    n = 0;
    while (!at_boundary() && n < 100) begin idle(1); n++; end
    chk("boundary_found", 32'(at_boundary()), 32'd1);
    cyc(0, 1, 2'd2, 32'h0000_000F);
    idle(3);
    // frozen scan holds the pending commit
    cyc(0, 1, 2'd3, 32'h0000_0000);
    cyc(0, 1, 2'd0, 32'hFFFF_0000);
    idle(70);
    cyc(0, 1, 2'd3, 32'h0000_0001);
    idle(40);
    // reset drops pending data
    cyc(0, 1, 2'd0, 32'h5555_5555);
    cyc(1, 0, 2'd0, 32'd0);
    idle(40);
    // test pattern on/off
    cyc(0, 1, 2'd3, 32'h0000_0005);
    idle(3);
    cyc(0, 1, 2'd3, 32'h0000_0001);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] s;
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0)
        cyc(1, 1'($urandom_range(0, 1)), s, $urandom());
      else if ($urandom_range(0, 3) == 0)
        cyc(0, 1, s, (s == 2'd3 && $urandom_range(0, 2) != 0) ? 32'($urandom_range(0, 7)) | 32'd1
                                                               : $urandom());
      else
        idle(1);
    end
    idle(2);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
